speck_round_scheduler: RTL and testbench

Iterative SPECK encryption controller. It owns the key schedule and the round counter, and it time-shares one external round-function datapath between two kinds of round: data rounds and key-expansion rounds. SPECK key expansion is the data round with the round index used as the subkey, so no second datapath is needed. The block sits between the cipher top level (start/done handshake, full key and plaintext) and a single round-function instance (start/finished handshake).

---
 rtl/speck_round_scheduler_pkg.sv | 21 ++
 rtl/speck_key_word_shifter.sv | 41 ++++
 rtl/speck_round_scheduler.sv | 159 +++++++++++++++
 tb/tb_speck_round_scheduler.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/speck_round_scheduler_pkg.sv
// Shared settings for the SPECK round scheduler and the round datapath:
// default sizes, scheduler state encodings and a small state helper.
package speck_round_scheduler_pkg;

   localparam int WORD_SIZE_DEF = 16;
   localparam int KEY_WORDS_DEF = 4;
   localparam int ROUNDS_DEF    = 22;

   localparam logic [2:0] ST_IDLE    = 3'd0;
   localparam logic [2:0] ST_LOAD    = 3'd1;
   localparam logic [2:0] ST_D_ISSUE = 3'd2;
   localparam logic [2:0] ST_D_WAIT  = 3'd3;
   localparam logic [2:0] ST_K_ISSUE = 3'd4;
   localparam logic [2:0] ST_K_WAIT  = 3'd5;
   localparam logic [2:0] ST_DONE    = 3'd6;

   function automatic logic is_issue(input logic [2:0] st);
      return (st == ST_D_ISSUE) || (st == ST_K_ISSUE);
   endfunction

endpackage

// File: rtl/speck_key_word_shifter.sv
// Three-deep key-word register l[0..2]: parallel load from the cipher key,
// shift toward l[0] with a new word entering at l[2] on each key round.
module speck_key_word_shifter
   import speck_round_scheduler_pkg::*;
#(
   parameter int WORD_SIZE = WORD_SIZE_DEF
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   load_i,
   input  logic                   shift_i,
   input  logic [3*WORD_SIZE-1:0] load_words_i,
   input  logic [WORD_SIZE-1:0]   shift_in_i,
   output logic [WORD_SIZE-1:0]   l0_o
);

   logic [2:0][WORD_SIZE-1:0] l_q;
   logic [2:0][WORD_SIZE-1:0] l_d;

   always_comb begin
      l_d = l_q;
      if (load_i) begin
         l_d = load_words_i;
      end else if (shift_i) begin
         l_d = {shift_in_i, l_q[2], l_q[1]};
      end else begin
         l_d = l_q;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         l_q <= '0;
      end else begin
         l_q <= l_d;
      end
   end

   assign l0_o = l_q[0];

endmodule

// File: rtl/speck_round_scheduler.sv
// Iterative SPECK controller: owns the key schedule and round counter and
// time-shares one external round datapath between data and key rounds.
module speck_round_scheduler
   import speck_round_scheduler_pkg::*;
#(
   parameter int WORD_SIZE = WORD_SIZE_DEF,
   parameter int KEY_WORDS = KEY_WORDS_DEF,
   parameter int ROUNDS    = ROUNDS_DEF
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic                           start,
   input  logic [WORD_SIZE*KEY_WORDS-1:0] key,
   input  logic [2*WORD_SIZE-1:0]         plaintext,
   output logic                           ready,
   output logic                           busy,
   output logic                           done,
   output logic [2*WORD_SIZE-1:0]         ciphertext,
   output logic [4:0]                     round_idx,
   output logic                           rf_start,
   output logic [WORD_SIZE-1:0]           rf_subkey,
   output logic [2*WORD_SIZE-1:0]         rf_in,
   input  logic [2*WORD_SIZE-1:0]         rf_out,
   input  logic                           rf_finished
);

   localparam int         W      = WORD_SIZE;
   localparam logic [4:0] LAST_R = 5'(ROUNDS - 1);

   logic [2:0]     state_q, state_d;
   logic [W-1:0]   x_q, x_d, y_q, y_d, k_q, k_d;
   logic [4:0]     r_q, r_d;
   logic           ready_q, busy_q, done_q, done_d, rf_start_q, rf_start_d;
   logic [2*W-1:0] ct_q, ct_d, rf_in_q, rf_in_d;
   logic [W-1:0]   rf_subkey_q, rf_subkey_d;
   logic           l_load_s, l_shift_s;
   logic [W-1:0]   l0_s;

   speck_key_word_shifter #(.WORD_SIZE(W)) u_key_words (
      .clk          (clk),
      .rst_n        (rst_n),
      .load_i       (l_load_s),
      .shift_i      (l_shift_s),
      .load_words_i (key[4*W-1:W]),
      .shift_in_i   (rf_out[W-1:0]),
      .l0_o         (l0_s)
   );

   always_comb begin
      state_d   = state_q;
      x_d       = x_q;
      y_d       = y_q;
      k_d       = k_q;
      r_d       = r_q;
      ct_d      = ct_q;
      done_d    = 1'b0;
      l_load_s  = 1'b0;
      l_shift_s = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (start) state_d = ST_LOAD;
            else       state_d = ST_IDLE;
         end
         ST_LOAD: begin
            x_d      = plaintext[W-1:0];
            y_d      = plaintext[2*W-1:W];
            k_d      = key[W-1:0];
            r_d      = 5'd0;
            l_load_s = 1'b1;
            state_d  = ST_D_ISSUE;
         end
         ST_D_ISSUE: state_d = ST_D_WAIT;
         ST_D_WAIT: begin
            if (rf_finished) begin
               x_d     = rf_out[W-1:0];
               y_d     = rf_out[2*W-1:W];
               state_d = (r_q == LAST_R) ? ST_DONE : ST_K_ISSUE;
            end else begin
               state_d = ST_D_WAIT;
            end
         end
         ST_K_ISSUE: state_d = ST_K_WAIT;
         // Key round result: x-half becomes the newest l word, y-half the next round key.
         ST_K_WAIT: begin
            if (rf_finished) begin
               l_shift_s = 1'b1;
               k_d       = rf_out[2*W-1:W];
               r_d       = r_q + 5'd1;
               state_d   = ST_D_ISSUE;
            end else begin
               state_d = ST_K_WAIT;
            end
         end
         ST_DONE: begin
            ct_d    = {y_q, x_q};
            done_d  = 1'b1;
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Datapath operands are registered one cycle ahead, using the next-state register values.
   always_comb begin
      rf_start_d  = is_issue(state_d);
      rf_in_d     = rf_in_q;
      rf_subkey_d = rf_subkey_q;
      if (state_d == ST_D_ISSUE) begin
         rf_in_d     = {y_d, x_d};
         rf_subkey_d = k_d;
      end else if (state_d == ST_K_ISSUE) begin
         rf_in_d     = {k_d, l0_s};
         rf_subkey_d = W'(r_d);
      end else begin
         rf_in_d     = rf_in_q;
         rf_subkey_d = rf_subkey_q;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         x_q         <= '0;
         y_q         <= '0;
         k_q         <= '0;
         r_q         <= 5'd0;
         ready_q     <= 1'b1;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         ct_q        <= '0;
         rf_start_q  <= 1'b0;
         rf_subkey_q <= '0;
         rf_in_q     <= '0;
      end else begin
         state_q     <= state_d;
         x_q         <= x_d;
         y_q         <= y_d;
         k_q         <= k_d;
         r_q         <= r_d;
         ready_q     <= (state_d == ST_IDLE);
         busy_q      <= (state_d != ST_IDLE);
         done_q      <= done_d;
         ct_q        <= ct_d;
         rf_start_q  <= rf_start_d;
         rf_subkey_q <= rf_subkey_d;
         rf_in_q     <= rf_in_d;
      end
   end

   assign ready      = ready_q;
   assign busy       = busy_q;
   assign done       = done_q;
   assign ciphertext = ct_q;
   assign round_idx  = r_q;
   assign rf_start   = rf_start_q;
   assign rf_subkey  = rf_subkey_q;
   assign rf_in      = rf_in_q;

endmodule

// File: tb/tb_speck_round_scheduler.sv
// Self-checking bench: round-datapath stub with variable latency, a SPECK
// reference model, vector table, random runs and multi-cycle corner sequences.
`timescale 1ns/1ps
module tb_speck_round_scheduler;

   localparam int R = 22;

   typedef struct packed { logic [31:0] in; logic [15:0] sk; } call_t;
   typedef struct {
      logic [63:0] key; logic [31:0] pt; int mode; int lm; bit spur; bit scr;
      int edge_n; logic [31:0] ct;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic [63:0] key = '0;
   logic [31:0] plaintext = '0;
   logic        ready, busy, done, rf_start, rf_finished;
   logic [31:0] ciphertext, rf_in, rf_out;
   logic [4:0]  round_idx;
   logic [15:0] rf_subkey;

   int checks = 0;
   int errors = 0;
   int rf_count = 0;
   call_t exp_calls[$];
   call_t model_calls[$];

   int dp_mode = 0;
   int lat_mode = 0;
   bit spur_en = 1'b0;
   int pend = 0;
   logic        fin_q = 1'b0, spur_q = 1'b0;
   logic [3:0]  lat_pick = 4'd1;
   logic [31:0] res_q = '0, hold_q = '0, junk_q = '0;

   always #5 clk = ~clk;

   speck_round_scheduler dut (
      .clk(clk), .rst_n(rst_n), .start(start), .key(key), .plaintext(plaintext),
      .ready(ready), .busy(busy), .done(done), .ciphertext(ciphertext),
      .round_idx(round_idx), .rf_start(rf_start), .rf_subkey(rf_subkey),
      .rf_in(rf_in), .rf_out(rf_out), .rf_finished(rf_finished)
   );

   function automatic logic [15:0] ror16(input logic [15:0] v, input int s);
      return (v >> s) | (v << (16 - s));
   endfunction

   // mode 0: SPECK32 round (alpha 7, beta 2); mode 1: xor-with-subkey stub
   function automatic logic [31:0] round_fn(input logic [31:0] in, input logic [15:0] sk, input int mode);
      logic [15:0] x, y;
      x = in[15:0];
      y = in[31:16];
      if (mode == 0) begin
         x = (ror16(x, 7) + y) ^ sk;
         y = ror16(y, 14) ^ x;
      end else begin
         x = x ^ sk;
         y = y ^ sk;
      end
      return {y, x};
   endfunction

   function automatic logic [31:0] model_encrypt(input logic [63:0] k_in, input logic [31:0] pt, input int mode);
      logic [15:0] l [0:R+2];
      logic [15:0] kk [0:R-1];
      logic [15:0] x, y;
      logic [31:0] o;
      model_calls.delete();
      kk[0] = k_in[15:0];
      l[0] = k_in[31:16];
      l[1] = k_in[47:32];
      l[2] = k_in[63:48];
      x = pt[15:0];
      y = pt[31:16];
      for (int i = 0; i < R; i++) begin
         model_calls.push_back('{in: {y, x}, sk: kk[i]});
         o = round_fn({y, x}, kk[i], mode);
         y = o[31:16];
         x = o[15:0];
         if (i < R - 1) begin
            model_calls.push_back('{in: {kk[i], l[i]}, sk: 16'(i)});
            o = round_fn({kk[i], l[i]}, 16'(i), mode);
            l[i+3]  = o[15:0];
            kk[i+1] = o[31:16];
         end
      end
      return {y, x};
   endfunction

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, got, exp);
      end
   endtask

   // Round datapath stub: latency L counted from the edge that samples rf_start.
   always @(posedge clk) begin
      fin_q    <= 1'b0;
      junk_q   <= $urandom;
      lat_pick <= 4'($urandom_range(1, 9));
      spur_q   <= spur_en && ($urandom_range(0, 1) == 1);
      if (rf_start) begin
         if (lat_mode == 0 || lat_pick == 4'd1) begin
            fin_q <= 1'b1;
            res_q <= round_fn(rf_in, rf_subkey, dp_mode);
            pend  <= 0;
         end else begin
            hold_q <= round_fn(rf_in, rf_subkey, dp_mode);
            pend   <= int'(lat_pick) - 1;
         end
      end else if (pend > 0) begin
         if (pend == 1) begin
            fin_q <= 1'b1;
            res_q <= hold_q;
         end
         pend <= pend - 1;
      end
   end

   assign rf_finished = fin_q | (spur_q & (rf_start | ready));
   assign rf_out      = fin_q ? res_q : junk_q;

   initial begin
      call_t c;
      bit prev_rf = 1'b0;
      forever begin
         @(negedge clk);
         if (rst_n) begin
            check("busy_inv", {63'd0, busy ^ ready}, 64'd1);
            if (rf_start) begin
               check("rf_start_gap", {63'd0, prev_rf}, 64'd0);
               rf_count++;
               check("rf_expected_call", {63'd0, exp_calls.size() != 0}, 64'd1);
               if (exp_calls.size() != 0) begin
                  c = exp_calls.pop_front();
                  check("rf_in", {32'd0, rf_in}, {32'd0, c.in});
                  check("rf_subkey", {48'd0, rf_subkey}, {48'd0, c.sk});
               end
            end
         end
         prev_rf = rf_start;
      end
   end

   task automatic run_enc(input string name, input logic [63:0] k, input logic [31:0] pt, input int mode,
                          input int lm, input bit spur, input bit scr, input int exp_edge, input logic [31:0] exp_ct);
      int n;
      bit got_done;
      logic [31:0] unused_ct;
      dp_mode  = mode;
      lat_mode = lm;
      spur_en  = spur;
      unused_ct = model_encrypt(k, pt, mode);
      n = 0;
      while (!ready && n < 600) begin
         @(negedge clk);
         n++;
      end
      check({name, "_ready_wait"}, {63'd0, ready}, 64'd1);
      exp_calls = model_calls;
      key = k;
      plaintext = pt;
      start = 1'b1;
      @(posedge clk);
      rf_count = 0;
      #1 start = 1'b0;
      n = 0;
      got_done = 1'b0;
      while (!got_done && n < 2000) begin
         @(posedge clk);
         n++;
         if (n == 1 && scr) begin
            #1;
            key = {$urandom, $urandom};
            plaintext = $urandom;
         end
         @(negedge clk);
         if (done) got_done = 1'b1;
      end
      check({name, "_done_seen"}, {63'd0, got_done}, 64'd1);
      check({name, "_ct"}, {32'd0, ciphertext}, {32'd0, exp_ct});
      if (exp_edge >= 0) check({name, "_done_edge"}, 64'(n), 64'(exp_edge));
      check({name, "_rf_count"}, 64'(rf_count), 64'd43);
      check({name, "_calls_left"}, 64'(exp_calls.size()), 64'd0);
      @(negedge clk);
      check({name, "_done_pulse"}, {63'd0, done}, 64'd0);
      check({name, "_ct_hold"}, {32'd0, ciphertext}, {32'd0, exp_ct});
      exp_calls.delete();
   endtask

   initial begin
      vec_t vecs [6];
      logic [63:0] rk;
      logic [31:0] rp, rc;
      int n, ndone, nready;

      repeat (3) @(negedge clk);
      check("rst_ready", {63'd0, ready}, 64'd1);
      check("rst_busy", {63'd0, busy}, 64'd0);
      check("rst_done", {63'd0, done}, 64'd0);
      check("rst_ct", {32'd0, ciphertext}, 64'd0);
      check("rst_round_idx", {59'd0, round_idx}, 64'd0);
      check("rst_rf_start", {63'd0, rf_start}, 64'd0);
      check("rst_rf_out_regs", {16'd0, rf_subkey, rf_in}, 64'd0);
      rst_n = 1'b1;
      @(negedge clk);

      rk = {$urandom, $urandom};
      rp = $urandom;
      vecs[0] = '{64'h1918111009080100, 32'h694c6574, 0, 0, 1'b0, 1'b0, 88, 32'h42f2a868};
      vecs[1] = '{64'h1918111009080100, 32'h694c6574, 0, 1, 1'b1, 1'b1, -1, 32'h42f2a868};
      vecs[2] = '{64'h0, 32'h0, 1, 0, 1'b0, 1'b0, 88, 32'h00160016};
      vecs[3] = '{rk, 32'hdeadbeef, 1, 0, 1'b0, 1'b1, 88, 32'hdeadbeef ^ 32'h00160016};
      vecs[4] = '{~rk, rp, 1, 1, 1'b1, 1'b1, -1, rp ^ 32'h00160016};
      vecs[5] = '{64'hffffffffffffffff, 32'ha5a55a5a, 0, 1, 1'b1, 1'b1, -1,
                  model_encrypt(64'hffffffffffffffff, 32'ha5a55a5a, 0)};
      for (int i = 0; i < 6; i++) begin
         run_enc($sformatf("vec%0d", i), vecs[i].key, vecs[i].pt, vecs[i].mode, vecs[i].lm,
                 vecs[i].spur, vecs[i].scr, vecs[i].edge_n, vecs[i].ct);
      end

      for (int i = 0; i < 6; i++) begin
         rk = {$urandom, $urandom};
         rp = $urandom;
         rc = model_encrypt(rk, rp, 0);
         run_enc($sformatf("rand%0d", i), rk, rp, 0, 1, 1'($urandom_range(0, 1)), 1'b1, -1, rc);
      end

      // start held high: two back-to-back encryptions, one ready cycle between them
      rk = {$urandom, $urandom};
      rp = $urandom;
      rc = model_encrypt(rk, rp, 0);
      dp_mode = 0; lat_mode = 1; spur_en = 1'b0;
      exp_calls = {model_calls, model_calls};
      key = rk;
      plaintext = rp;
      start = 1'b1;
      ndone = 0; nready = 0; n = 0;
      while (ndone < 2 && n < 3000) begin
         @(negedge clk);
         n++;
         if (done) begin
            ndone++;
            check("b2b_ct", {32'd0, ciphertext}, {32'd0, rc});
            if (ndone == 2) start = 1'b0;
         end
         if (ndone == 1 && ready) nready++;
      end
      check("b2b_done_count", 64'(ndone), 64'd2);
      check("b2b_ready_gap", 64'(nready), 64'd1);
      check("b2b_calls_left", 64'(exp_calls.size()), 64'd0);
      exp_calls.delete();
      @(negedge clk);

      // reset pulsed in round 10
      rc = model_encrypt(64'h1918111009080100, 32'h694c6574, 0);
      dp_mode = 0; lat_mode = 1; spur_en = 1'b0;
      exp_calls = model_calls;
      key = 64'h1918111009080100;
      plaintext = 32'h694c6574;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      n = 0;
      while (round_idx != 5'd10 && n < 2000) begin
         @(negedge clk);
         n++;
      end
      check("rst_mid_reached_r10", {59'd0, round_idx}, 64'd10);
      rst_n = 1'b0;
      #1;
      check("rst_mid_ready", {63'd0, ready}, 64'd1);
      check("rst_mid_busy", {63'd0, busy}, 64'd0);
      check("rst_mid_done", {63'd0, done}, 64'd0);
      check("rst_mid_ct", {32'd0, ciphertext}, 64'd0);
      check("rst_mid_round_idx", {59'd0, round_idx}, 64'd0);
      check("rst_mid_rf_start", {63'd0, rf_start}, 64'd0);
      check("rst_mid_rf_regs", {16'd0, rf_subkey, rf_in}, 64'd0);
      exp_calls.delete();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      ndone = 0;
      for (int i = 0; i < 15; i++) begin
         @(negedge clk);
         if (done) ndone++;
      end
      check("rst_mid_no_done", 64'(ndone), 64'd0);
      run_enc("after_rst", 64'h1918111009080100, 32'h694c6574, 0, 1, 1'b1, 1'b1, -1, 32'h42f2a868);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
